// File: rtl/pn_seq_pkg.sv
// PN sequence generator shared types, default polynomials and the single LFSR step.
// Pure definitions, no latency; no flow control.
package pn_seq_pkg;

    localparam int unsigned PN_MAX_W = 32;

    typedef logic [PN_MAX_W-1:0] pn_state_t;

    // Fibonacci tap masks: bit i set means state bit i feeds the XOR.
    localparam logic [6:0]  PN7_TAPS  = 7'b1001110;
    localparam logic [6:0]  PN7_SEED  = 7'h7F;
    localparam logic [8:0]  PN9_TAPS  = 9'h110;
    localparam logic [8:0]  PN9_SEED  = 9'h1FF;
    localparam logic [14:0] PN15_TAPS = 15'h6000;
    localparam logic [14:0] PN15_SEED = 15'h7FFF;
    localparam logic [22:0] PN23_TAPS = 23'h420000;
    localparam logic [22:0] PN23_SEED = 23'h7FFFFF;
    localparam logic [30:0] PN31_TAPS = 31'h48000000;
    localparam logic [30:0] PN31_SEED = 31'h7FFFFFFF;

    // One shift: the oldest bit leaves from the top, feedback enters at bit 0.
    function automatic pn_state_t lfsr_step(input pn_state_t s, input pn_state_t taps,
                                            input int unsigned w);
        pn_state_t mask;
        mask = (w >= PN_MAX_W) ? '1 : ((pn_state_t'(1) << w) - pn_state_t'(1));
        return {s[PN_MAX_W-2:0], ^(s & taps)} & mask;
    endfunction

    function automatic int unsigned pn_ofs_w(input int unsigned out_w);
        return (out_w > 1) ? $clog2(out_w) : 1;
    endfunction

endpackage

// File: rtl/pn_seq_gen_unroll.sv
// Combinational OUT_W-step LFSR unroll: beat bits (oldest at MSB) and the state after them.
// Zero latency; no flow control.
module pn_lfsr_unroll
    import pn_seq_pkg::*;
#(
    parameter int unsigned         LFSR_W = 7,
    parameter logic [LFSR_W-1:0]   TAPS   = PN7_TAPS,
    parameter int unsigned         OUT_W  = 1
) (
    input  logic [LFSR_W-1:0] s,
    output logic [OUT_W-1:0]  bits,
    output logic [LFSR_W-1:0] s_next
);

    pn_state_t walk;

    always_comb begin
        walk = pn_state_t'(s);
        bits = '0;
        for (int k = 0; k < OUT_W; k++) begin
            bits[OUT_W-1-k] = walk[LFSR_W-1];
            walk = lfsr_step(walk, pn_state_t'(TAPS), LFSR_W);
        end
        s_next = walk[LFSR_W-1:0];
    end

endmodule

// File: rtl/pn_seq_gen.sv
// PN generator: OUT_W bits per beat, seed load, period marking; PN_LOCKUP_RECOVER_EN swaps zero seeds for SEED.
// Latency: one cycle from an advancing cycle to dout_valid.
// Backpressure: beat held stable while dout_valid && !dout_ready; dout_ready never reaches dout_valid combinationally.
module pn_seq_gen
    import pn_seq_pkg::*;
#(
    parameter int unsigned       LFSR_W = 7,
    parameter logic [LFSR_W-1:0] TAPS   = PN7_TAPS,
    parameter logic [LFSR_W-1:0] SEED   = '1,
    parameter int unsigned       OUT_W  = 1,
    localparam int unsigned      OFS_W  = pn_ofs_w(OUT_W)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed_in,
    output logic [OUT_W-1:0]  dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              frame_start,
    output logic [OFS_W-1:0]  frame_ofs,
    output logic              lockup
);

    // Counter runs mod 2^LFSR_W-1, so its last value is all-ones minus one.
    localparam logic [LFSR_W-1:0] CNT_LAST = {{(LFSR_W-1){1'b1}}, 1'b0};
    localparam logic [LFSR_W-1:0] CNT_ONE  = {{(LFSR_W-1){1'b0}}, 1'b1};

    logic [LFSR_W-1:0] s;
    logic [LFSR_W-1:0] s_adv;
    logic [LFSR_W-1:0] cnt;
    logic [LFSR_W-1:0] cnt_adv;
    logic [LFSR_W-1:0] cnt_walk;
    logic [LFSR_W-1:0] load_val;
    logic [OUT_W-1:0]  beat;
    logic              beat_fs;
    logic [OFS_W-1:0]  beat_ofs;
    logic              adv;

    pn_lfsr_unroll #(
        .LFSR_W (LFSR_W),
        .TAPS   (TAPS),
        .OUT_W  (OUT_W)
    ) u_unroll (
        .s      (s),
        .bits   (beat),
        .s_next (s_adv)
    );

    assign adv = en && (!dout_valid || dout_ready) && !seed_load;

    // Walk the counter across the beat; the first position that hits 0 is the period start.
    always_comb begin
        cnt_walk = cnt;
        beat_fs  = 1'b0;
        beat_ofs = '0;
        for (int k = 0; k < OUT_W; k++) begin
            if (!beat_fs && cnt_walk == '0) begin
                beat_fs  = 1'b1;
                beat_ofs = OFS_W'(k);
            end
            cnt_walk = (cnt_walk == CNT_LAST) ? '0 : cnt_walk + CNT_ONE;
        end
        cnt_adv = cnt_walk;
    end

`ifdef PN_LOCKUP_RECOVER_EN
    logic lockup_q;

    assign load_val = (seed_in == '0) ? SEED : seed_in;
    assign lockup   = lockup_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            lockup_q <= 1'b0;
        end else begin
            lockup_q <= seed_load && (seed_in == '0);
        end
    end
`else
    assign load_val = seed_in;
    assign lockup   = (s == '0);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            s           <= SEED;
            cnt         <= '0;
            dout        <= '0;
            dout_valid  <= 1'b0;
            frame_start <= 1'b0;
            frame_ofs   <= '0;
        end else if (seed_load) begin
            s          <= load_val;
            cnt        <= '0;
            dout_valid <= 1'b0;
        end else if (adv) begin
            s           <= s_adv;
            cnt         <= cnt_adv;
            dout        <= beat;
            dout_valid  <= 1'b1;
            frame_start <= beat_fs;
            frame_ofs   <= beat_ofs;
        end else if (dout_ready) begin
            dout_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pn_seq_gen.sv
// Bench for pn_seq_gen: 1-bit and 8-bit beat instances driven by shared stimulus.
module tb_pn_seq_gen;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       seed_load;
    logic [6:0] seed_in;
    logic       dout_ready;

    logic [0:0] d1;
    logic       v1, fs1, lk1;
    logic [0:0] o1;
    logic [7:0] d8;
    logic       v8, fs8, lk8;
    logic [2:0] o8;

    int n_chk  = 0;
    int n_pass = 0;

    logic seq [0:126];

    logic       m_vld, m_fresh, m_d1, m_fs1, m_fs8;
    logic [7:0] m_d8;
    logic [2:0] m_ofs8;
    int         m_idx1, m_beat;

    typedef struct {
        logic en;
        logic rdy;
        logic vld;
        logic chk_dat;
        logic d;
        logic fs;
    } vec_t;

    vec_t vt [0:14];

    always #5 clk = ~clk;

    pn_seq_gen u_dut1 (
        .clk(clk), .reset(reset), .en(en), .seed_load(seed_load), .seed_in(seed_in),
        .dout(d1), .dout_valid(v1), .dout_ready(dout_ready),
        .frame_start(fs1), .frame_ofs(o1), .lockup(lk1)
    );

    pn_seq_gen #(.OUT_W(8)) u_dut8 (
        .clk(clk), .reset(reset), .en(en), .seed_load(seed_load), .seed_in(seed_in),
        .dout(d8), .dout_valid(v8), .dout_ready(dout_ready),
        .frame_start(fs8), .frame_ofs(o8), .lockup(lk8)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_edge(input logic e, input logic r);
        int b;
        m_fresh = 1'b0;
        if (e && (!m_vld || r)) begin
            m_vld   = 1'b1;
            m_fresh = 1'b1;
            m_d1    = seq[m_idx1 % 127];
            m_fs1   = (m_idx1 % 127 == 0);
            m_idx1++;
            m_fs8  = 1'b0;
            m_ofs8 = 3'd0;
            for (int k = 0; k < 8; k++) begin
                b = 8 * m_beat + k;
                m_d8[7-k] = seq[b % 127];
                if (!m_fs8 && (b % 127 == 0)) begin
                    m_fs8  = 1'b1;
                    m_ofs8 = 3'(k);
                end
            end
            m_beat++;
        end else if (r) begin
            m_vld = 1'b0;
        end
    endtask

    initial begin
        logic [6:0] s;
        reset = 1'b1; en = 1'b0; seed_load = 1'b0; seed_in = 7'h00; dout_ready = 1'b0;

        s = 7'h7F;
        for (int i = 0; i < 127; i++) begin
            seq[i] = s[6];
            s = {s[5:0], ^(s & 7'b1001110)};
        end

        // Reset state
        tick(); tick();
        chk("rst_vld1", 32'(v1), 32'd0);
        chk("rst_dout1", 32'(d1), 32'd0);
        chk("rst_fs1", 32'(fs1), 32'd0);
        chk("rst_ofs1", 32'(o1), 32'd0);
        chk("rst_lk1", 32'(lk1), 32'd0);
        chk("rst_vld8", 32'(v8), 32'd0);
        chk("rst_dout8", 32'(d8), 32'd0);
        chk("rst_fs8", 32'(fs8), 32'd0);
        chk("rst_ofs8", 32'(o8), 32'd0);
        chk("rst_lk8", 32'(lk8), 32'd0);
        reset = 1'b0;

        // Hand-computed 1-bit stream: 1,1,1,1,1,1,1,0,0,1,0 with holds and idles mixed in
        vt[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[1]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        vt[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        vt[3]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        vt[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        vt[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[6]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        vt[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        vt[8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        vt[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        vt[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        vt[11] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[12] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[13] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        vt[14] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 15; i++) begin
            en = vt[i].en;
            dout_ready = vt[i].rdy;
            tick();
            chk($sformatf("tab%0d_vld", i), 32'(v1), 32'(vt[i].vld));
            if (vt[i].chk_dat) begin
                chk($sformatf("tab%0d_dout", i), 32'(d1), 32'(vt[i].d));
                chk($sformatf("tab%0d_fs", i), 32'(fs1), 32'(vt[i].fs));
            end
        end

        // Long stream across two periods with a 5-cycle stall
        reset = 1'b1; en = 1'b0; dout_ready = 1'b1;
        tick();
        reset = 1'b0;
        m_vld = 1'b0; m_idx1 = 0; m_beat = 0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            en = 1'b1;
            dout_ready = !(cyc >= 60 && cyc < 65);
            tick();
            model_edge(en, dout_ready);
            chk("str_vld1", 32'(v1), 32'(m_vld));
            chk("str_vld8", 32'(v8), 32'(m_vld));
            if (m_vld) begin
                chk("str_dout1", 32'(d1), 32'(m_d1));
                chk("str_fs1", 32'(fs1), 32'(m_fs1));
                chk("str_dout8", 32'(d8), 32'(m_d8));
                chk("str_fs8", 32'(fs8), 32'(m_fs8));
                if (m_fs8) chk("str_ofs8", 32'(o8), 32'(m_ofs8));
            end
            if (m_fresh && m_beat == 1) chk("beat0_dout8", 32'(d8), 32'h0FE);
            if (m_fresh && m_beat == 16) begin
                chk("beat15_fs8", 32'(fs8), 32'd1);
                chk("beat15_ofs8", 32'(o8), 32'd7);
            end
        end

        // Seed load with a beat pending
        dout_ready = 1'b0;
        tick();
        chk("sl_pre_vld", 32'(v1), 32'd1);
        seed_load = 1'b1; seed_in = 7'h01;
        tick();
        chk("sl_vld1", 32'(v1), 32'd0);
        chk("sl_vld8", 32'(v8), 32'd0);
        seed_load = 1'b0; dout_ready = 1'b1;
        tick();
        chk("sl_nvld1", 32'(v1), 32'd1);
        chk("sl_dout1", 32'(d1), 32'd0);
        chk("sl_fs1", 32'(fs1), 32'd1);
        chk("sl_ofs1", 32'(o1), 32'd0);
        chk("sl_dout8", 32'(d8), 32'h02);
        chk("sl_fs8", 32'(fs8), 32'd1);
        chk("sl_ofs8", 32'(o8), 32'd0);

        // Zero seed
        seed_load = 1'b1; seed_in = 7'h00;
        tick();
        chk("z_vld8", 32'(v8), 32'd0);
        chk("z_lk1", 32'(lk1), 32'd1);
        chk("z_lk8", 32'(lk8), 32'd1);
        seed_load = 1'b0;
        tick();
        chk("z_vld_a", 32'(v8), 32'd1);
        chk("z_fs_a", 32'(fs8), 32'd1);
`ifdef PN_LOCKUP_RECOVER_EN
        chk("z_lk_a", 32'(lk8), 32'd0);
        chk("z_dout8_a", 32'(d8), 32'h0FE);
        chk("z_dout1_a", 32'(d1), 32'd1);
        tick();
        chk("z_dout8_b", 32'(d8), 32'h40);
        chk("z_lk_b", 32'(lk1), 32'd0);
`else
        chk("z_lk_a", 32'(lk8), 32'd1);
        chk("z_dout8_a", 32'(d8), 32'h00);
        chk("z_dout1_a", 32'(d1), 32'd0);
        tick();
        chk("z_dout8_b", 32'(d8), 32'h00);
        chk("z_lk_b", 32'(lk1), 32'd1);
`endif

        // Reset mid-handshake
        dout_ready = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        chk("mr_vld1", 32'(v1), 32'd0);
        chk("mr_dout1", 32'(d1), 32'd0);
        chk("mr_vld8", 32'(v8), 32'd0);
        chk("mr_dout8", 32'(d8), 32'd0);
        chk("mr_fs8", 32'(fs8), 32'd0);
        chk("mr_lk8", 32'(lk8), 32'd0);
        reset = 1'b0; dout_ready = 1'b1; en = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            chk($sformatf("mr_bit%0d_vld", i), 32'(v1), 32'd1);
            chk($sformatf("mr_bit%0d", i), 32'(d1), 32'd1);
            if (i == 0) begin
                chk("mr_dout8", 32'(d8), 32'h0FE);
                chk("mr_fs1", 32'(fs1), 32'd1);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
